// File: rtl/router_out_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : router_out_arbiter_if
// Purpose  : Bundle of the input-side and output-side handshake signals of one
//            router output-port arbiter.
// Signals  : in_valid/in_head/in_tail/in_flit  per-input flit offer
//            in_ready                          per-input grant (one-hot/zero)
//            out_valid/out_flit/out_tail       registered output flit
//            out_ready                         downstream accept
//            router_conflict/conflict_cnt/pkt_cnt  statistics
// Modports : slave  = arbiter view, master = environment view
// Revision : 1.0  initial release
// ============================================================================
interface router_out_arbiter_if #(
  parameter int NUM_IN = 5,
  parameter int FLIT_W = 64,
  parameter int CNT_W  = 32
);
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN-1:0]        in_head;
  logic [NUM_IN-1:0]        in_tail;
  logic [NUM_IN*FLIT_W-1:0] in_flit;
  logic [NUM_IN-1:0]        in_ready;
  logic                     out_valid;
  logic [FLIT_W-1:0]        out_flit;
  logic                     out_tail;
  logic                     out_ready;
  logic                     router_conflict;
  logic [CNT_W-1:0]         conflict_cnt;
  logic [CNT_W-1:0]         pkt_cnt;

  modport slave (
    input  in_valid, in_head, in_tail, in_flit, out_ready,
    output in_ready, out_valid, out_flit, out_tail,
           router_conflict, conflict_cnt, pkt_cnt
  );

  modport master (
    output in_valid, in_head, in_tail, in_flit, out_ready,
    input  in_ready, out_valid, out_flit, out_tail,
           router_conflict, conflict_cnt, pkt_cnt
  );
endinterface
`default_nettype wire

// File: rtl/router_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : router_out_arbiter
// Purpose  : Wormhole output-port arbiter. Round-robin arbitration among
//            NUM_IN inputs on head flits, link locked to the winner until its
//            tail flit, one-stage registered output, contention statistics.
// Ports    : clk     clock, rising edge
//            arst_n  asynchronous active-low reset
//            bus     router_out_arbiter_if.slave (flit handshakes + stats)
// Revision : 1.0  initial release
// ============================================================================
module router_out_arbiter #(
  parameter int NUM_IN = 5,
  parameter int FLIT_W = 64,
  parameter int CNT_W  = 32
) (
  input  wire logic              clk,
  input  wire logic              arst_n,
  router_out_arbiter_if.slave    bus
);

  localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_owner;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic               r_out_valid;
  logic [FLIT_W-1:0]  r_out_flit;
  logic               r_out_tail;
  logic               r_conflict;
  logic [CNT_W-1:0]   r_conflict_cnt;
  logic [CNT_W-1:0]   r_pkt_cnt;

  logic               w_can_accept;
  logic [NUM_IN-1:0]  w_cand;
  logic [NUM_IN-1:0]  w_owner_oh;
  logic [PTR_W-1:0]   w_winner;
  logic               w_win_found;
  logic [PTR_W-1:0]   w_sel;
  logic [NUM_IN-1:0]  w_grant;
  logic               w_xfer;
  logic               w_sel_tail;
  logic [FLIT_W-1:0]  w_sel_flit;
  logic               w_contend;
  logic [PTR_W-1:0]   w_rr_next;

  assign w_can_accept = !r_out_valid || bus.out_ready;
  assign w_cand       = bus.in_valid & bus.in_head;
  assign w_owner_oh   = NUM_IN'(1) << r_owner;

  // Rotating-priority search: scanning from the far end toward rr_ptr lets
  // the candidate closest to rr_ptr overwrite any earlier hit.
  always_comb begin
    int idx;
    w_winner    = '0;
    w_win_found = 1'b0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (w_cand[idx]) begin
        w_winner    = PTR_W'(idx);
        w_win_found = 1'b1;
      end
    end
  end

  assign w_sel = (r_state == S_LOCKED) ? r_owner : w_winner;

  always_comb begin
    w_grant = '0;
    if (w_can_accept) begin
      if (r_state == S_LOCKED)
        w_grant = w_owner_oh;
      else if (w_win_found)
        w_grant = NUM_IN'(1) << w_winner;
    end
  end

  assign w_xfer     = |(w_grant & bus.in_valid);
  assign w_sel_tail = bus.in_tail[w_sel];
  assign w_sel_flit = bus.in_flit[w_sel*FLIT_W +: FLIT_W];
  assign w_rr_next  = (int'(w_sel) == NUM_IN - 1) ? '0 : w_sel + PTR_W'(1);

  // Idle: two or more competing heads. Locked: any head from a non-owner.
  assign w_contend = (r_state == S_IDLE)
                   ? ((w_cand & (w_cand - NUM_IN'(1))) != '0)
                   : ((w_cand & ~w_owner_oh) != '0);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state        <= S_IDLE;
      r_owner        <= '0;
      r_rr_ptr       <= '0;
      r_out_valid    <= 1'b0;
      r_out_flit     <= '0;
      r_out_tail     <= 1'b0;
      r_conflict     <= 1'b0;
      r_conflict_cnt <= '0;
      r_pkt_cnt      <= '0;
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_flit  <= w_sel_flit;
        r_out_tail  <= w_sel_tail;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_xfer) begin
        if (w_sel_tail) begin
          r_state  <= S_IDLE;
          r_rr_ptr <= w_rr_next;
          if (r_pkt_cnt != '1) r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
        end else if (r_state == S_IDLE) begin
          r_state <= S_LOCKED;
          r_owner <= w_sel;
        end
      end

      r_conflict <= w_contend;
      if (w_contend && (r_conflict_cnt != '1))
        r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready        = w_grant;
  assign bus.out_valid       = r_out_valid;
  assign bus.out_flit        = r_out_flit;
  assign bus.out_tail        = r_out_tail;
  assign bus.router_conflict = r_conflict;
  assign bus.conflict_cnt    = r_conflict_cnt;
  assign bus.pkt_cnt         = r_pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_router_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_out_arbiter
// Purpose  : Self-checking bench for router_out_arbiter. Two instances share
//            the stimulus: one with 32-bit counters, one with 4-bit counters
//            so that saturation is reachable.
// Revision : 1.0  initial release
// ============================================================================
module tb_router_out_arbiter;

  localparam int N  = 5;
  localparam int FW = 64;

  logic           clk;
  logic           arst_n;
  logic [N-1:0]   v, h, t;
  logic [N*FW-1:0] f;
  logic           ordy;

  int n_err;
  int n_chk;
  int cyc_no;

  // Reference model state
  int          m_owner;   // -1 when idle
  int          m_rr;
  logic        m_ov;
  logic [63:0] m_flit;
  logic        m_tail;
  logic        m_conf;
  longint      m_cc;
  longint      m_pc;

  router_out_arbiter_if #(.NUM_IN(N), .FLIT_W(FW), .CNT_W(32)) ifa ();
  router_out_arbiter_if #(.NUM_IN(N), .FLIT_W(FW), .CNT_W(4))  ifb ();

  assign ifa.in_valid = v;  assign ifb.in_valid = v;
  assign ifa.in_head  = h;  assign ifb.in_head  = h;
  assign ifa.in_tail  = t;  assign ifb.in_tail  = t;
  assign ifa.in_flit  = f;  assign ifb.in_flit  = f;
  assign ifa.out_ready = ordy; assign ifb.out_ready = ordy;

  router_out_arbiter #(.NUM_IN(N), .FLIT_W(FW), .CNT_W(32)) dut_a (
    .clk(clk), .arst_n(arst_n), .bus(ifa.slave));
  router_out_arbiter #(.NUM_IN(N), .FLIT_W(FW), .CNT_W(4)) dut_b (
    .clk(clk), .arst_n(arst_n), .bus(ifb.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic longint sat15(input longint x);
    return (x > 15) ? 15 : x;
  endfunction

  // Grant predicted directly from the arbitration rules.
  function automatic logic [N-1:0] m_ready();
    logic can;
    can = !m_ov || ordy;
    if (!can) return '0;
    if (m_owner >= 0) return N'(1) << m_owner;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (v[i] && h[i]) return N'(1) << i;
    end
    return '0;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_ov = 1'b0; m_flit = '0; m_tail = 1'b0;
    m_conf = 1'b0; m_cc = 0; m_pc = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] r;
    int xi;
    int nc;
    r  = m_ready();
    xi = -1;
    nc = 0;
    for (int i = 0; i < N; i++) begin
      if (r[i] && v[i]) xi = i;
      if (v[i] && h[i] && (m_owner < 0 || i != m_owner)) nc++;
    end
    m_conf = (m_owner < 0) ? (nc >= 2) : (nc >= 1);
    if (m_conf && m_cc < 64'hFFFF_FFFF) m_cc++;
    if (xi >= 0) begin
      m_ov   = 1'b1;
      m_flit = f[xi*FW +: FW];
      m_tail = t[xi];
      if (t[xi]) begin
        m_owner = -1;
        m_rr    = (xi + 1) % N;
        if (m_pc < 64'hFFFF_FFFF) m_pc++;
      end else begin
        m_owner = xi;
      end
    end else if (ordy) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic chk_out(input string tag);
    chk({tag, " out_valid"},    64'(ifa.out_valid),       64'(m_ov));
    chk({tag, " out_flit"},     ifa.out_flit,             m_flit);
    chk({tag, " out_tail"},     64'(ifa.out_tail),        64'(m_tail));
    chk({tag, " conflict"},     64'(ifa.router_conflict), 64'(m_conf));
    chk({tag, " conflict_cnt"}, 64'(ifa.conflict_cnt),    m_cc);
    chk({tag, " pkt_cnt"},      64'(ifa.pkt_cnt),         m_pc);
    chk({tag, " conflict_cnt4"}, 64'(ifb.conflict_cnt),   sat15(m_cc));
    chk({tag, " pkt_cnt4"},     64'(ifb.pkt_cnt),         sat15(m_pc));
  endtask

  task automatic set_flits();
    for (int i = 0; i < N; i++)
      f[i*FW +: FW] = {8'(i), 24'h0, 32'(cyc_no)};
  endtask

  // One clock of stimulus; called just after a falling edge.
  task automatic cyc(input logic [N-1:0] vv, input logic [N-1:0] hh,
                     input logic [N-1:0] tt, input logic rdy_in,
                     input bit use_exp, input logic [N-1:0] exp_rdy,
                     input string tag);
    v = vv; h = hh; t = tt; ordy = rdy_in;
    cyc_no++;
    set_flits();
    #1;
    chk({tag, " in_ready"}, 64'(ifa.in_ready), 64'(m_ready()));
    chk({tag, " in_ready4"}, 64'(ifb.in_ready), 64'(m_ready()));
    if (use_exp) chk({tag, " in_ready vec"}, 64'(ifa.in_ready), 64'(exp_rdy));
    model_step();
    @(posedge clk);
    #1;
    chk_out(tag);
    @(negedge clk);
  endtask

  typedef struct {
    logic [N-1:0] v, h, t;
    logic         ordy;
    logic [N-1:0] rdy;
    logic         conf;
  } vec_t;

  vec_t   tbl[11];
  longint cc0;

  initial begin
    n_err = 0; n_chk = 0; cyc_no = 0;
    v = '0; h = '0; t = '0; ordy = 1'b0; f = '0;
    arst_n = 1'b0;
    model_reset();

    // Round robin among five single-flit streams, then one stray body flit.
    for (int i = 0; i < 10; i++)
      tbl[i] = '{v: 5'b11111, h: 5'b11111, t: 5'b11111, ordy: 1'b1,
                 rdy: N'(1) << (i % N), conf: 1'b1};
    tbl[10] = '{v: 5'b10000, h: 5'b00000, t: 5'b00000, ordy: 1'b1,
                rdy: 5'b00000, conf: 1'b0};

    repeat (3) @(negedge clk);
    chk_out("reset");
    arst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].v, tbl[i].h, tbl[i].t, tbl[i].ordy, 1'b1, tbl[i].rdy, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d conflict vec", i), 64'(ifa.router_conflict), 64'(tbl[i].conf));
    end
    chk("rr pkt_cnt", 64'(ifa.pkt_cnt), 64'd10);

    // Wormhole lock: input 1 4-flit packet, input 3 single-flit head waiting.
    cc0 = m_cc;
    cyc(5'b01010, 5'b01010, 5'b01000, 1'b1, 1'b1, 5'b00010, "wh0");
    cyc(5'b01010, 5'b01000, 5'b01000, 1'b1, 1'b1, 5'b00010, "wh1");
    cyc(5'b01010, 5'b01000, 5'b01000, 1'b1, 1'b1, 5'b00010, "wh2");
    cyc(5'b01010, 5'b01000, 5'b01010, 1'b1, 1'b1, 5'b00010, "wh3");
    chk("wh conflict delta", 64'(ifa.conflict_cnt) - 64'(cc0), 64'd4);
    cyc(5'b01000, 5'b01000, 5'b01000, 1'b1, 1'b1, 5'b01000, "wh4");
    chk("wh4 out from in3", 64'(ifa.out_flit[63:56]), 64'd3);

    // Backpressure on a 2-flit packet from input 0.
    cyc(5'b00001, 5'b00001, 5'b00000, 1'b1, 1'b1, 5'b00001, "bp0");
    for (int i = 0; i < 3; i++)
      cyc(5'b00001, 5'b00000, 5'b00001, 1'b0, 1'b1, 5'b00000, $sformatf("bp_hold%0d", i));
    cyc(5'b00001, 5'b00000, 5'b00001, 1'b1, 1'b1, 5'b00001, "bp1");
    chk("bp1 out_tail vec", 64'(ifa.out_tail), 64'd1);
    cyc(5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b1, 5'b00000, "bp2");

    // Reset in the middle of a 3-flit packet on input 2.
    cyc(5'b00100, 5'b00100, 5'b00000, 1'b1, 1'b1, 5'b00100, "mr0");
    cyc(5'b00100, 5'b00000, 5'b00000, 1'b1, 1'b1, 5'b00100, "mr1");
    v = '0; h = '0; t = '0;
    #2 arst_n = 1'b0;
    #1;
    model_reset();
    chk_out("mid reset");
    @(negedge clk);
    arst_n = 1'b1;
    cyc(5'b00100, 5'b00100, 5'b00100, 1'b1, 1'b1, 5'b00100, "mr2");

    // Saturation of the 4-bit counter.
    for (int i = 0; i < 20; i++)
      cyc(5'b11111, 5'b11111, 5'b11111, 1'b1, 1'b0, 5'b00000, "sat");
    chk("sat conflict_cnt4", 64'(ifb.conflict_cnt), 64'd15);
    chk("sat conflict_cnt", 64'(ifa.conflict_cnt), 64'd20);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++)
      cyc(N'($urandom), N'($urandom), N'($urandom), ($urandom_range(0, 3) != 0),
          1'b0, 5'b00000, "rnd");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/router_out_arbiter.md
# router_out_arbiter

Wormhole output-port arbiter for one router output of the aggregation-engine mesh NoC. It shares a single output link among NUM_IN input ports (local PE, N, E, S, W) with round-robin fairness and locks the link to one packet from head flit to tail flit. It drives a one-stage registered output and flags the per-cycle conflicts that the NoC benches accumulate as router conflict counts. One instance sits per output port inside each router.

## Interface
- NUM_IN, 5, number of competing input ports (index 0 = local PE).
- FLIT_W, 64, flit payload width in bits.
- CNT_W, 32, width of the statistics counters.

- clk  in  1  clock; all state updates on rising edge.
- arst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  NUM_IN  per-input flit valid.
- in_head  in  NUM_IN  per-input head-flit marker (qualified by in_valid).
- in_tail  in  NUM_IN  per-input tail-flit marker; head and tail both set means a single-flit packet.
- in_flit  in  NUM_IN*FLIT_W  per-input payload; input i occupies bits [i*FLIT_W +: FLIT_W].
- in_ready  out  NUM_IN  one-hot or zero; the flit on input i transfers when in_valid[i] & in_ready[i].
- out_valid  out  1  registered output flit valid.
- out_flit  out  FLIT_W  registered output payload.
- out_tail  out  1  registered tail marker of out_flit.
- out_ready  in  1  downstream accepts out_flit when out_valid & out_ready.
- router_conflict  out  1  registered; high for one cycle after a cycle with contention.
- conflict_cnt  out  CNT_W  saturating count of contention cycles.
- pkt_cnt  out  CNT_W  saturating count of tail flits forwarded.

## Operation
- State: IDLE or LOCKED(owner); rr_ptr in [0, NUM_IN-1] is the highest-priority input.
- can_accept = !out_valid | out_ready (the output register is empty or draining this cycle).
- IDLE: candidates = in_valid & in_head. The winner is the first candidate scanning rr_ptr, rr_ptr+1, … modulo NUM_IN. in_ready = onehot(winner) & can_accept; all zero if there are no candidates.
- LOCKED(owner): in_ready = onehot(owner) & can_accept. in_head on the owner is ignored, so the flit is treated as a body flit. Non-owners are never granted.
- Transfer from input i loads out_flit/out_tail from input i and sets out_valid=1. If the output pops with no transfer, out_valid is set to 0.
- Head transfer without tail: go to LOCKED(i).
- Tail transfer in either state: go to IDLE, set rr_ptr = (i+1) mod NUM_IN, and increment pkt_cnt.
- Contention cycle:
  - In IDLE, at least 2 bits of in_valid & in_head are set.
  - In LOCKED, any non-owner has in_valid & in_head set.
  - A contention cycle sets router_conflict=1 next cycle and increments conflict_cnt. Otherwise router_conflict=0.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Non-head flits presented in IDLE are never granted and do not count as contention.

## Timing
- Reset (async assert, any state including mid-packet): IDLE, rr_ptr=0, out_valid=0, out_flit=0, out_tail=0, router_conflict=0, conflict_cnt=0, pkt_cnt=0. The partial packet is abandoned.
- in_ready is combinational from state, rr_ptr, in_valid, in_head and out_valid/out_ready. It has no path from in_flit.
- Latency is 1 cycle: a flit transferred at edge N is on out_flit after edge N and remains stable until popped.
- Full throughput is 1 flit/cycle when out_ready stays high.
- With out_valid=1 and out_ready=0, in_ready=0 and the output holds.
- Simultaneous pop and load in the same cycle: out_valid stays 1 with the new flit.
- A single-flit packet (head & tail) never enters LOCKED; rr_ptr advances at the same edge.
- A tail transfer and a new candidate's head in the same cycle: the new head waits one cycle, until the edge in IDLE.
- rr_ptr changes only on tail transfer.

## Test plan
- Reset mid-packet: lock input 2 with a 3-flit packet, assert arst_n=0 after flit 2 → out_valid=0, rr_ptr=0, counters 0. After release, a head on input 2 alone is granted from IDLE.
- Round-robin fairness: inputs 0–4 each continuously present 1-flit packets (head&tail), out_ready=1 → grant order is 0,1,2,3,4,0…; router_conflict=1 on every cycle after the first; pkt_cnt=10 after 10 flits.
- Wormhole lock: input 1 sends 4 flits (head, body, body, tail) while input 3 holds a head → out_flit shows all 4 input-1 flits back-to-back, then input 3. conflict_cnt increments on each of the 4 cycles.
- Backpressure: 2-flit packet on input 0, out_ready=0 for 3 cycles after the first flit → out_flit is held, in_ready=0. After out_ready returns, the second flit appears 1 cycle later with no loss or duplication.
- Saturation: CNT_W=4 with 20 contention cycles → conflict_cnt=15 and stays at 15.
- Stray body flit: in_valid[4]=1 with in_head[4]=0 in IDLE → in_ready=0, router_conflict stays 0, no output.
